// File: rtl/posit_decode_pipe_pkg.sv
// posit_decode_pipe_pkg: width derivations and constant builders shared by the posit decoder,
// its bus interface and the regime counter.
package posit_decode_pipe_pkg;

    // Ceiling log2, used only at elaboration time to size fields.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

    // Exponent bias: the most negative regime maps to a biased exponent of zero.
    function automatic int bias_of(input int n, input int es);
        return (n - 2) << es;
    endfunction

    // Biased exponent width, wide enough for 0..2*BIAS.
    function automatic int ew_of(input int n, input int es);
        return clog2(2 * bias_of(n, es) + 1);
    endfunction

    // Fraction width: the body minus the shortest regime (2 bits) and the exponent field.
    function automatic int fw_of(input int n, input int es);
        return n - 3 - es;
    endfunction

    // Width of the packed {exponent, fraction} result.
    function automatic int ow_of(input int n, input int es);
        return ew_of(n, es) + fw_of(n, es);
    endfunction

    // NaR pattern: sign bit set, everything else clear.
    function automatic logic [63:0] nar_pattern(input int n);
        return 64'd1 << (n - 1);
    endfunction

    // Zero pattern: every bit clear.
    function automatic logic [63:0] zero_pattern();
        return 64'd0;
    endfunction

endpackage

// File: rtl/posit_decode_pipe_if.sv
// posit_decode_pipe_if: input stream (posit operands) and output stream (decoded eposits)
// of the posit decoder. The decoder uses the slave modport, its environment the master.
interface posit_decode_pipe_if
    import posit_decode_pipe_pkg::*;
#(
    parameter int N  = 8,
    parameter int ES = 0
);
    localparam int OW = ow_of(N, ES);

    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_posit;
    logic          out_valid;
    logic          out_ready;
    logic          out_sign;
    logic          out_zero;
    logic          out_nar;
    logic [OW-1:0] out_eposit;

    modport slave (
        input  in_valid, in_posit, out_ready,
        output in_ready, out_valid, out_sign, out_zero, out_nar, out_eposit
    );

    modport master (
        output in_valid, in_posit, out_ready,
        input  in_ready, out_valid, out_sign, out_zero, out_nar, out_eposit
    );

endinterface

// File: rtl/posit_decode_pipe_regime_counter.sv
// posit_regime_counter: combinational run-length counter over the posit body (sign removed).
// Reports the length of the leading run of identical bits and the polarity of that run.
module posit_regime_counter #(
    parameter int W  = 7,
    parameter int MW = 3
) (
    input  logic [W-1:0]  body,
    output logic [MW-1:0] run_len,
    output logic          polarity
);

    logic running;

    // Count from the MSB down until the first bit that differs from the MSB.
    always_comb begin
        polarity = body[W-1];
        run_len  = '0;
        running  = 1'b1;
        for (int i = W - 1; i >= 0; i--) begin
            if (running && (body[i] == polarity)) begin
                run_len = run_len + MW'(1);
            end else begin
                running = 1'b0;
            end
        end
    end

endmodule

// File: rtl/posit_decode_pipe.sv
// posit_decode_pipe: two-stage valid/ready posit decoder. Produces sign, zero/NaR flags and
// eposit = {biased exponent, left-aligned fraction}, for the mullin multiply core.
// Build option POSIT_DEC_NEG_EN: negative posits are two's-complemented before regime
// decode so eposit describes |x|; when undefined the body is decoded as given (sign-magnitude).
module posit_decode_pipe
    import posit_decode_pipe_pkg::*;
#(
    parameter int N  = 8,
    parameter int ES = 0
) (
    input logic                clk,
    input logic                rst,
    posit_decode_pipe_if.slave bus
);

    localparam int W    = N - 1;
    localparam int MW   = clog2(N);
    localparam int BIAS = bias_of(N, ES);
    localparam int EW   = ew_of(N, ES);
    localparam int FW   = fw_of(N, ES);
    localparam int OW   = ow_of(N, ES);
    localparam logic [N-1:0] NAR  = N'(nar_pattern(N));
    localparam logic [N-1:0] ZERO = N'(zero_pattern());

    logic          s1_ready, s2_ready;
    logic          in_sign, in_zero, in_nar;
    logic [W-1:0]  body_in;
    logic [MW-1:0] run_len;
    logic          polarity;

    logic          s1_valid, s1_sign, s1_zero, s1_nar, s1_r;
    logic [MW-1:0] s1_m;
    logic [W-1:0]  s1_body;

    logic [MW:0]   shift_amt;
    logic [W-1:0]  shifted;
    int            k_val, es_val, biased_val;
    logic [EW-1:0] exp_bits;
    logic [FW-1:0] frac_bits;
    logic [OW-1:0] eposit_next;

    logic          s2_valid, s2_sign, s2_zero, s2_nar;
    logic [OW-1:0] s2_eposit;

    // A stage may load when it is empty or its contents leave in the same cycle.
    assign s2_ready = !s2_valid || bus.out_ready;
    assign s1_ready = !s1_valid || s2_ready;

    // Classify the incoming posit and pick the body that feeds the regime counter.
    always_comb begin
        in_sign = bus.in_posit[N-1];
        in_zero = (bus.in_posit == ZERO);
        in_nar  = (bus.in_posit == NAR);
`ifdef POSIT_DEC_NEG_EN
        if (in_sign && !in_nar) begin
            body_in = W'(ZERO - bus.in_posit);
        end else begin
            body_in = bus.in_posit[W-1:0];
        end
`else
        body_in = bus.in_posit[W-1:0];
`endif
    end

    posit_regime_counter #(
        .W  (W),
        .MW (MW)
    ) u_regime (
        .body     (body_in),
        .run_len  (run_len),
        .polarity (polarity)
    );

    // Stage 1 register: flags, regime run length/polarity and the body for the shifter.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_zero  <= 1'b0;
            s1_nar   <= 1'b0;
            s1_r     <= 1'b0;
            s1_m     <= '0;
            s1_body  <= '0;
        end else if (s1_ready) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_sign <= in_sign;
                s1_zero <= in_zero;
                s1_nar  <= in_nar;
                s1_r    <= polarity;
                s1_m    <= run_len;
                s1_body <= body_in;
            end
        end
    end

    // Strip regime and terminator, split exponent bits from fraction, form the biased exponent.
    // A run to the LSB shifts everything out, leaving zero exponent bits and fraction.
    always_comb begin
        shift_amt  = {1'b0, s1_m} + (MW + 1)'(1);
        shifted    = s1_body << shift_amt;
        k_val      = s1_r ? (int'(s1_m) - 1) : -int'(s1_m);
        es_val     = int'(shifted >> (W - ES));
        biased_val = k_val * (1 << ES) + es_val + BIAS;
        exp_bits   = EW'(biased_val);
        frac_bits  = FW'(shifted >> 2);
        if (s1_zero || s1_nar) begin
            eposit_next = '0;
        end else begin
            eposit_next = {exp_bits, frac_bits};
        end
    end

    // Stage 2 register: holds the result steady until the consumer takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_sign   <= 1'b0;
            s2_zero   <= 1'b0;
            s2_nar    <= 1'b0;
            s2_eposit <= '0;
        end else if (s2_ready) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sign   <= s1_sign;
                s2_zero   <= s1_zero;
                s2_nar    <= s1_nar;
                s2_eposit <= eposit_next;
            end
        end
    end

    assign bus.in_ready   = s1_ready;
    assign bus.out_valid  = s2_valid;
    assign bus.out_sign   = s2_sign;
    assign bus.out_zero   = s2_zero;
    assign bus.out_nar    = s2_nar;
    assign bus.out_eposit = s2_eposit;

endmodule
